// File: rtl/ysyx_22040088_div_seq_if.sv
// Request/response bundle between EX issue logic and the sequential divider.
// The master drives the operation and consumes the result; the divider is the slave.
interface ysyx_22040088_div_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            div_valid;
  logic            div_ready;
  logic            op_signed;
  logic            op_rem;
  logic            op_word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output div_valid, op_signed, op_rem, op_word, src1, src2, flush, out_ready,
    input  div_ready, out_valid, result, busy
  );

  modport slave (
    input  div_valid, op_signed, op_rem, op_word, src1, src2, flush, out_ready,
    output div_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_22040088_div_seq.sv
// Radix-2 restoring divider for the RV64M div/rem family, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and answer the cycle after accept.
module ysyx_22040088_div_seq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040088_div_seq_if.slave bus
);

  localparam int unsigned WW = 32;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CntWord = CNT_W'(WW - 1);
  localparam logic [XLEN-1:0] MinFull = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinWord = {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            op_rem_q, op_rem_d;
  logic            op_word_q, op_word_d;
  logic            out_valid_q, out_valid_d;

  function automatic logic [XLEN-1:0] sext_w(input logic [WW-1:0] v);
    return {{(XLEN-WW){v[WW-1]}}, v};
  endfunction

  // Operand pre-processing on the live request
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, zero_rem;
  logic            neg_a, neg_b, div_zero, sign_ovf;

  always_comb begin
    if (bus.op_word) begin
      a_ext = bus.op_signed ? sext_w(bus.src1[WW-1:0])
                            : {{(XLEN-WW){1'b0}}, bus.src1[WW-1:0]};
      b_ext = bus.op_signed ? sext_w(bus.src2[WW-1:0])
                            : {{(XLEN-WW){1'b0}}, bus.src2[WW-1:0]};
      zero_rem = sext_w(bus.src1[WW-1:0]);
    end else begin
      a_ext    = bus.src1;
      b_ext    = bus.src2;
      zero_rem = bus.src1;
    end
    neg_a    = bus.op_signed & a_ext[XLEN-1];
    neg_b    = bus.op_signed & b_ext[XLEN-1];
    abs_a    = neg_a ? -a_ext : a_ext;
    abs_b    = neg_b ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    sign_ovf = bus.op_signed && (a_ext == (bus.op_word ? MinWord : MinFull)) && (b_ext == '1);
  end

  // Trial subtraction; the extra top bit is the borrow that decides restore vs keep
  logic [XLEN+1:0] trial;
  assign trial = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};

  logic [XLEN-1:0] quo_fix, rem_fix, sel, fix_result;

  always_comb begin
    quo_fix    = neg_quo_q ? -quo_q : quo_q;
    rem_fix    = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    sel        = op_rem_q ? rem_fix : quo_fix;
    fix_result = op_word_q ? sext_w(sel[WW-1:0]) : sel;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    op_rem_d    = op_rem_q;
    op_word_d   = op_word_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.div_valid && !bus.flush) begin
          op_rem_d  = bus.op_rem;
          op_word_d = bus.op_word;
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          dvs_d     = abs_b;
          rem_d     = '0;
          // Word dividends sit in the top half so Q's msb feeds the first iteration
          quo_d     = bus.op_word ? {abs_a[WW-1:0], {(XLEN-WW){1'b0}}} : abs_a;
          cnt_d     = bus.op_word ? CntWord : CntFull;
          if (div_zero) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            result_d    = bus.op_rem ? zero_rem : '1;
          end else if (sign_ovf) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            result_d    = bus.op_rem ? '0 : a_ext;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (!trial[XLEN+1]) begin
            rem_d = trial[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          result_d    = fix_result;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.flush || bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      op_rem_q    <= 1'b0;
      op_word_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      result_q    <= result_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      op_rem_q    <= op_rem_d;
      op_word_q   <= op_word_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.div_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_ysyx_22040088_div_seq.sv
// Directed bench for the sequential divider: expected results queued at issue,
// popped and checked when out_valid rises, with latency and control checks alongside.
module tb_ysyx_22040088_div_seq;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] exp_q[$];

  ysyx_22040088_div_seq_if #(.XLEN(64)) bus ();

  ysyx_22040088_div_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    bus.op_signed = s;
    bus.op_rem    = r;
    bus.op_word   = w;
    bus.src1      = a;
    bus.src2      = b;
    bus.div_valid = 1'b1;
  endtask

  task automatic issue(input logic s, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    drive(s, r, w, a, b);
    exp_q.push_back(exp);
  endtask

  // Called at the negedge before the accept edge; returns at the negedge where out_valid is seen.
  task automatic collect(input string tag, input int lat);
    int n = 1;
    logic [63:0] exp;
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    bus.src1 = {$urandom, $urandom};
    bus.src2 = {$urandom, $urandom};
    check({tag, " busy/ready"}, {62'b0, bus.busy, bus.div_ready}, 64'b10);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, " result"}, bus.result, exp);
  endtask

  task automatic release_chk(input string tag);
    @(negedge clk);
    check({tag, " release"}, {62'b0, bus.out_valid, bus.div_ready}, 64'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.div_valid = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_rem    = 1'b0;
    bus.op_word   = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ctl", {60'b0, bus.busy, bus.div_ready, bus.out_valid, 1'b0}, 64'b0100);
    check("reset result", bus.result, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 0, 0, 64'd100, 64'd7, 64'd14);
    collect("divu", 66);
    release_chk("divu");
    issue(0, 1, 0, 64'd100, 64'd7, 64'd2);
    collect("remu", 66);
    release_chk("remu");
    issue(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("rem", 66);
    release_chk("rem");
    issue(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    collect("div", 66);
    release_chk("div");
    issue(1, 0, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    collect("divw ovf", 1);
    release_chk("divw ovf");
    issue(1, 1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    collect("remw ovf", 1);
    release_chk("remw ovf");
    issue(0, 0, 0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("divu by0", 1);
    release_chk("divu by0");
    issue(0, 1, 1, 64'h0000_0000_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001);
    collect("remuw by0", 1);
    release_chk("remuw by0");
    issue(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("divuw", 34);
    release_chk("divuw");
    issue(1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    collect("div ovf", 1);
    release_chk("div ovf");

    // Flush in IDLE blocks the accept
    drive(0, 0, 0, 64'd50, 64'd5);
    bus.flush = 1'b1;
    @(negedge clk);
    check("idle flush", {62'b0, bus.busy, bus.div_ready}, 64'b01);
    bus.flush     = 1'b0;
    bus.div_valid = 1'b0;

    // Flush mid-CALC discards the operation
    drive(1, 0, 0, 64'd1000, 64'd3);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("calc flush", {61'b0, bus.busy, bus.div_ready, bus.out_valid}, 64'b010);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    check("no pulse after flush", {63'b0, seen}, 64'h0);
    issue(0, 0, 0, 64'd9, 64'd3, 64'd3);
    collect("divu post-flush", 66);
    release_chk("divu post-flush");

    // Backpressure in DONE, then a request raised in the consume cycle
    bus.out_ready = 1'b0;
    issue(0, 0, 0, 64'd1000, 64'd10, 64'd100);
    collect("bp", 66);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold result", bus.result, 64'd100);
      check("bp hold ctl", {62'b0, bus.out_valid, bus.div_ready}, 64'b10);
    end
    bus.out_ready = 1'b1;
    issue(0, 0, 0, 64'd20, 64'd4, 64'd5);
    @(negedge clk);
    check("consume no accept", {61'b0, bus.out_valid, bus.busy, bus.div_ready}, 64'b001);
    collect("divu after consume", 66);
    release_chk("divu after consume");

    // Reset mid-CALC
    drive(0, 0, 0, 64'd12345, 64'd7);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid calc ctl", {61'b0, bus.busy, bus.div_ready, bus.out_valid}, 64'b010);
    check("rst mid calc result", bus.result, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("remw", 34);
    release_chk("remw");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_div_seq.md
Name: ysyx_22040088_div_seq

Overview:
- Multi-cycle radix-2 restoring divide sequencer for the RV64M divide/remainder class: div, divu, rem, remu, divw, divuw, remw, remuw.
- Sits beside the single-cycle ALU in EX. Decode raises div_valid with the operation qualifiers, and the pipeline stalls while busy is high.
- Handles the RISC-V special cases (divide-by-zero, signed overflow) in one cycle, and supports flush and result backpressure.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- div_valid  input  1  request present; operands and qualifiers are valid.
- div_ready  output  1  sequencer can accept; high only in IDLE.
- op_signed  input  1  1 = div/rem/divw/remw; 0 = unsigned variants.
- op_rem  input  1  1 = return remainder; 0 = return quotient.
- op_word  input  1  1 = *w variant, uses 32-bit operands.
- src1  input  XLEN  dividend (rs1).
- src2  input  XLEN  divisor (rs2).
- flush  input  1  kill the in-flight operation (branch redirect).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  final, sign-adjusted result.
- busy  output  1  high whenever state is not IDLE; used as the stall.

Behaviour:
- Reset (rst high at an edge): state=IDLE, counter=0, out_valid=0, result=0, busy=0, div_ready=1. Reset overrides every other input, including an operation mid-CALC.
- States:
  - IDLE: accept when div_valid && div_ready && !flush. Latch the qualifiers, pre-processed operands and the sign flags. Go to DONE if a special case applies, otherwise to CALC.
  - CALC: one quotient bit per cycle; the counter decrements from N-1 to 0. N=32 if op_word, else 64. After the cycle with counter==0, go to FIX.
  - FIX: one cycle. Negate the quotient if sign(dividend)^sign(divisor) and signed. Negate the remainder if sign(dividend) and signed. Apply word sign-extension. Register the result and set out_valid. Go to DONE.
  - DONE: out_valid=1, and result is held stable. On out_ready, out_valid=0 next cycle and state=IDLE.
- Operand pre-processing:
  - Word ops take src[31:0], sign-extended if op_signed, else zero-extended.
  - Signed ops divide on absolute values.
- Iteration: remainder register R (XLEN+1 bits) and quotient register Q. Each CALC cycle: R' = {R, Q[msb]} - divisor. If non-negative, keep R' and shift 1 into Q. Otherwise restore and shift 0.
- Word result: low 32 bits of the selected value, sign-extended to 64 bits. This applies to divuw/remuw as well, per the ISA.
- Special cases, detected in IDLE at accept; FIX and CALC are skipped and out_valid rises the cycle after accept:
  - Divisor==0: quotient = all ones (word: 0xFFFFFFFF sign-extended). Remainder = dividend (word: sign-extended low 32 bits).
  - Signed overflow (dividend = most-negative for the width, divisor = -1): quotient = dividend; remainder = 0.
- Latency from the accept edge to out_valid high: N+2 cycles normally (66 for 64-bit, 34 for word); 1 cycle for special cases.
- flush:
  - In CALC/FIX/DONE: state=IDLE, out_valid=0 on the next edge, and no result is delivered.
  - In IDLE: no accept, even if div_valid is high.
  - Flush and out_ready together in DONE: flush wins; the result is discarded, with the same end state.
- div_ready=1 only in IDLE. A new request cannot be accepted in the same cycle a DONE result is consumed; it is accepted the next cycle.
- A new operation overwrites result only at FIX or at the special-case load. While not out_valid, result keeps its last value, which consumers must not sample.
- Operands are not re-read after accept; src1/src2 may change freely during CALC.

Test Plan:
- divu src1=100, src2=7, out_ready=1 -> div_ready drops after accept; out_valid at accept+66; result=14. Same operands with remu -> result=2.
- Signed rem src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2 -> result=0xFFFF_FFFF_FFFF_FFFF (-1). div with the same operands -> result=0xFFFF_FFFF_FFFF_FFFD (-3).
- divw src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> out_valid at accept+1; result=0xFFFF_FFFF_8000_0000. remw with the same operands -> result=0.
- divu src1=0x1234, src2=0 -> result=0xFFFF_FFFF_FFFF_FFFF at accept+1. remuw src1=0x0000_0000_8000_0001, src2=0 -> result=0xFFFF_FFFF_8000_0001.
- divuw src1=0xFFFF_FFFF_FFFF_FFFF, src2=1 -> out_valid at accept+34; result=0xFFFF_FFFF_FFFF_FFFF.
- Control sequencing:
  - flush at accept+10 of a 64-bit div -> busy=0 and div_ready=1 next cycle, with no out_valid pulse. A new divu 9/3 then returns 3.
  - Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stay stable and div_ready stays 0.
  - Assert rst mid-CALC -> all outputs return to reset values on the next edge.
